// File: rtl/cu_pkg.sv
// Shared decode definitions: RV32I opcodes, ALU operation codes and the decoded bundle.
package cu_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef enum logic [4:0] {
    AluAdd    = 5'd0,
    AluSub    = 5'd1,
    AluSll    = 5'd2,
    AluSlt    = 5'd3,
    AluSltu   = 5'd4,
    AluXor    = 5'd5,
    AluSrl    = 5'd6,
    AluSra    = 5'd7,
    AluOr     = 5'd8,
    AluAnd    = 5'd9,
    AluPassB  = 5'd10,
    AluMul    = 5'd16,
    AluMulh   = 5'd17,
    AluMulhsu = 5'd18,
    AluMulhu  = 5'd19,
    AluDiv    = 5'd20,
    AluDivu   = 5'd21,
    AluRem    = 5'd22,
    AluRemu   = 5'd23
  } alu_op_e;

  // pc/imm are carried at 64 bits; the stage truncates to XLEN (values are pre-sign-extended).
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    alu_op_e     alu;
    logic        alu_src_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_size;
    logic        mem_to_reg;
    logic        branch;
    logic [2:0]  branch_funct3;
    logic        jump;
    logic        jalr;
    logic        lui;
    logic        auipc;
    logic        illegal;
  } decode_bundle_t;

  // Base integer ops by funct3; alt selects SUB/SRA.
  function automatic alu_op_e alu_base(logic [2:0] f3, logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  function automatic alu_op_e alu_mul(logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = AluMul;
      3'b001:  op = AluMulh;
      3'b010:  op = AluMulhsu;
      3'b011:  op = AluMulhu;
      3'b100:  op = AluDiv;
      3'b101:  op = AluDivu;
      3'b110:  op = AluRem;
      default: op = AluRemu;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cu_decode_stage_if.sv
// Fetch-side and execute-side handshake plus decoded outputs of the decode stage.
interface cu_decode_stage_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ALU_CTRL_W = 6,
  parameter int unsigned CNT_W      = 16
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [XLEN-1:0]       in_pc;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_pc;
  logic [4:0]            out_rd;
  logic [4:0]            out_rs1;
  logic [4:0]            out_rs2;
  logic [XLEN-1:0]       out_imm;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  alu_src_imm;
  logic                  reg_write;
  logic                  mem_read;
  logic                  mem_write;
  logic [2:0]            mem_size;
  logic                  mem_to_reg;
  logic                  branch;
  logic [2:0]            branch_funct3;
  logic                  jump;
  logic                  jalr;
  logic                  lui_control;
  logic                  auipc_control;
  logic                  illegal;
  logic [CNT_W-1:0]      illegal_count;

  // Fetch/downstream side.
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm, alu_control,
           alu_src_imm, reg_write, mem_read, mem_write, mem_size, mem_to_reg, branch,
           branch_funct3, jump, jalr, lui_control, auipc_control, illegal, illegal_count
  );

  // Decode stage side.
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm, alu_control,
           alu_src_imm, reg_write, mem_read, mem_write, mem_size, mem_to_reg, branch,
           branch_funct3, jump, jalr, lui_control, auipc_control, illegal, illegal_count
  );
endinterface

// File: rtl/cu_decode_comb.sv
// Purely combinational RV32I (+ optional M) decoder: instruction word to decode bundle.
module cu_decode_comb
  import cu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned SUPPORT_M = 0
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output decode_bundle_t  o_bundle
);

  logic [6:0]     w_opcode, w_f7, w_shift_top;
  logic [2:0]     w_f3;
  logic [5:0]     w_shamt;
  logic [63:0]    w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic           w_ill;
  decode_bundle_t w_dec;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  // RV64 shifts take a 6-bit shamt, so only instr[31:26] are function bits there.
  assign w_shift_top = (XLEN == 64) ? {i_instr[31:26], 1'b0} : i_instr[31:25];
  assign w_shamt     = (XLEN == 64) ? i_instr[25:20] : {1'b0, i_instr[24:20]};

  assign w_imm_i = {{52{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{51{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                    i_instr[11:8], 1'b0};
  assign w_imm_u = {{32{i_instr[31]}}, i_instr[31:12], 12'b0};
  assign w_imm_j = {{43{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                    i_instr[30:21], 1'b0};

  // Per-opcode field decode; unused register indices stay 0.
  always_comb begin
    w_dec = '0;
    w_ill = 1'b0;
    case (w_opcode)
      OP: begin
        w_dec.rd        = i_instr[11:7];
        w_dec.rs1       = i_instr[19:15];
        w_dec.rs2       = i_instr[24:20];
        w_dec.reg_write = 1'b1;
        if (w_f7 == 7'b0000000) begin
          w_dec.alu = alu_base(w_f3, 1'b0);
        end else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
          w_dec.alu = alu_base(w_f3, 1'b1);
        end else if (w_f7 == 7'b0000001 && SUPPORT_M != 0) begin
          w_dec.alu = alu_mul(w_f3);
        end else begin
          w_ill = 1'b1;
        end
      end
      OP_IMM: begin
        w_dec.rd          = i_instr[11:7];
        w_dec.rs1         = i_instr[19:15];
        w_dec.imm         = w_imm_i;
        w_dec.alu_src_imm = 1'b1;
        w_dec.reg_write   = 1'b1;
        w_dec.alu         = alu_base(w_f3, 1'b0);
        if (w_f3 == 3'b001) begin
          w_dec.imm = 64'(w_shamt);
          if (w_shift_top != 7'b0000000) w_ill = 1'b1;
        end else if (w_f3 == 3'b101) begin
          w_dec.imm = 64'(w_shamt);
          if (w_shift_top == 7'b0100000) w_dec.alu = AluSra;
          else if (w_shift_top != 7'b0000000) w_ill = 1'b1;
        end
      end
      LOAD: begin
        w_dec.rd          = i_instr[11:7];
        w_dec.rs1         = i_instr[19:15];
        w_dec.imm         = w_imm_i;
        w_dec.alu_src_imm = 1'b1;
        w_dec.reg_write   = 1'b1;
        w_dec.mem_read    = 1'b1;
        w_dec.mem_to_reg  = 1'b1;
        w_dec.mem_size    = w_f3;
        if (w_f3 == 3'b011 || w_f3[2:1] == 2'b11) w_ill = 1'b1;
      end
      STORE: begin
        w_dec.rs1         = i_instr[19:15];
        w_dec.rs2         = i_instr[24:20];
        w_dec.imm         = w_imm_s;
        w_dec.alu_src_imm = 1'b1;
        w_dec.mem_write   = 1'b1;
        w_dec.mem_size    = w_f3;
        if (w_f3 >= 3'b011) w_ill = 1'b1;
      end
      BRANCH: begin
        w_dec.rs1           = i_instr[19:15];
        w_dec.rs2           = i_instr[24:20];
        w_dec.imm           = w_imm_b;
        w_dec.alu           = AluSub;
        w_dec.branch        = 1'b1;
        w_dec.branch_funct3 = w_f3;
        if (w_f3[2:1] == 2'b01) w_ill = 1'b1;
      end
      JAL: begin
        w_dec.rd        = i_instr[11:7];
        w_dec.imm       = w_imm_j;
        w_dec.reg_write = 1'b1;
        w_dec.jump      = 1'b1;
      end
      JALR: begin
        w_dec.rd          = i_instr[11:7];
        w_dec.rs1         = i_instr[19:15];
        w_dec.imm         = w_imm_i;
        w_dec.alu_src_imm = 1'b1;
        w_dec.reg_write   = 1'b1;
        w_dec.jalr        = 1'b1;
        if (w_f3 != 3'b000) w_ill = 1'b1;
      end
      LUI: begin
        w_dec.rd          = i_instr[11:7];
        w_dec.imm         = w_imm_u;
        w_dec.alu         = AluPassB;
        w_dec.alu_src_imm = 1'b1;
        w_dec.reg_write   = 1'b1;
        w_dec.lui         = 1'b1;
      end
      AUIPC: begin
        w_dec.rd          = i_instr[11:7];
        w_dec.imm         = w_imm_u;
        w_dec.alu_src_imm = 1'b1;
        w_dec.reg_write   = 1'b1;
        w_dec.auipc       = 1'b1;
      end
      FENCE:   ;  // NOP: no controls
      SYSTEM:  w_ill = 1'b1;  // no CSR support
      default: w_ill = 1'b1;
    endcase
  end

  // Illegal bundles carry only pc and the flag; writes to x0 are suppressed.
  always_comb begin
    o_bundle    = w_dec;
    o_bundle.pc = 64'(i_pc);
    if (w_ill) begin
      o_bundle         = '0;
      o_bundle.pc      = 64'(i_pc);
      o_bundle.illegal = 1'b1;
    end
    o_bundle.reg_write = o_bundle.reg_write && (o_bundle.rd != 5'd0);
  end

endmodule

// File: rtl/cu_decode_stage.sv
// Registered decode stage: combinational decode into an output register with a one-entry skid.
module cu_decode_stage
  import cu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ALU_CTRL_W = 6,
  parameter int unsigned SUPPORT_M  = 0,
  parameter int unsigned CNT_W      = 16
) (
  input logic            clk,
  input logic            reset,
  cu_decode_stage_if.slave bus
);

  decode_bundle_t   w_dec, r_out, r_skid;
  logic             r_out_valid, r_skid_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_in_ready, w_in_fire, w_out_fire;
  logic             w_unused;

  cu_decode_comb #(
    .XLEN      (XLEN),
    .SUPPORT_M (SUPPORT_M)
  ) u_dec (
    .i_instr  (bus.in_instr),
    .i_pc     (bus.in_pc),
    .o_bundle (w_dec)
  );

  // Ready depends only on held state and flush, never on out_ready.
  assign w_in_ready = !reset && !r_skid_valid && !bus.flush;
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;

  // Output register and skid buffer; flush drops everything held and incoming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (bus.flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_out_fire) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  // Saturating count of accepted (never flushed) illegal instructions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_in_fire && w_dec.illegal && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_pc        = r_out.pc[XLEN-1:0];
  assign bus.out_imm       = r_out.imm[XLEN-1:0];
  assign bus.out_rd        = r_out.rd;
  assign bus.out_rs1       = r_out.rs1;
  assign bus.out_rs2       = r_out.rs2;
  assign bus.alu_control   = ALU_CTRL_W'(r_out.alu);
  assign bus.alu_src_imm   = r_out.alu_src_imm;
  assign bus.reg_write     = r_out.reg_write;
  assign bus.mem_read      = r_out.mem_read;
  assign bus.mem_write     = r_out.mem_write;
  assign bus.mem_size      = r_out.mem_size;
  assign bus.mem_to_reg    = r_out.mem_to_reg;
  assign bus.branch        = r_out.branch;
  assign bus.branch_funct3 = r_out.branch_funct3;
  assign bus.jump          = r_out.jump;
  assign bus.jalr          = r_out.jalr;
  assign bus.lui_control   = r_out.lui;
  assign bus.auipc_control = r_out.auipc;
  assign bus.illegal       = r_out.illegal;
  assign bus.illegal_count = r_cnt;

  // Upper pc/imm bits above XLEN are intentionally dropped.
  assign w_unused = ^{r_out.imm, r_out.pc};

endmodule

// File: tb/tb_cu_decode_stage.sv
// Directed bench for cu_decode_stage with an in-order expected-bundle scoreboard.
module tb_cu_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [5:0]  alu;
    logic        src_imm, reg_write, mem_read, mem_write;
    logic [2:0]  mem_size;
    logic        mem_to_reg, branch;
    logic [2:0]  bf3;
    logic        jump, jalr, lui, auipc, illegal;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cu_decode_stage_if #(.XLEN(32), .ALU_CTRL_W(6), .CNT_W(4))  bus0 ();
  cu_decode_stage_if #(.XLEN(32), .ALU_CTRL_W(6), .CNT_W(16)) bus1 ();

  cu_decode_stage #(.XLEN(32), .ALU_CTRL_W(6), .SUPPORT_M(0), .CNT_W(4)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  cu_decode_stage #(.XLEN(32), .ALU_CTRL_W(6), .SUPPORT_M(1), .CNT_W(16)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  int         n_assert = 0;
  int         n_fail = 0;
  exp_t       q[$];
  exp_t       cur;
  exp_t       e;
  logic [3:0] cnt = 4'd0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t z(input logic [31:0] pc);
    exp_t r;
    r = '0;
    r.pc = pc;
    return r;
  endfunction

  function automatic exp_t ill(input logic [31:0] pc);
    exp_t r;
    r = z(pc);
    r.illegal = 1'b1;
    return r;
  endfunction

  function automatic exp_t got0();
    exp_t r;
    r.pc = bus0.out_pc;           r.imm = bus0.out_imm;
    r.rd = bus0.out_rd;           r.rs1 = bus0.out_rs1;         r.rs2 = bus0.out_rs2;
    r.alu = bus0.alu_control;     r.src_imm = bus0.alu_src_imm; r.reg_write = bus0.reg_write;
    r.mem_read = bus0.mem_read;   r.mem_write = bus0.mem_write; r.mem_size = bus0.mem_size;
    r.mem_to_reg = bus0.mem_to_reg; r.branch = bus0.branch;     r.bf3 = bus0.branch_funct3;
    r.jump = bus0.jump;           r.jalr = bus0.jalr;           r.lui = bus0.lui_control;
    r.auipc = bus0.auipc_control; r.illegal = bus0.illegal;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    bus0.in_valid = v;  bus0.in_instr = ins; bus0.in_pc = pc;
    bus0.flush = fl;    bus0.out_ready = ordy;
    bus1.in_valid = v;  bus1.in_instr = ins; bus1.in_pc = pc;
    bus1.flush = fl;    bus1.out_ready = ordy;
  endtask

  // Check held state at the falling edge, update the model for the coming rising edge.
  task automatic tick();
    logic exp_ready;
    @(negedge clk);
    exp_ready = !bus0.flush && (q.size() < 2);
    chk("in_ready", bus0.in_ready, exp_ready);
    chk("out_valid", bus0.out_valid, q.size() > 0);
    chk("illegal_count", bus0.illegal_count, cnt);
    if (q.size() > 0) begin
      chk("bundle", got0(), q[0]);
      if (bus0.out_ready && !bus0.flush) void'(q.pop_front());
    end
    if (bus0.flush) begin
      q.delete();
    end else if (bus0.in_valid && exp_ready) begin
      q.push_back(cur);
      if (cur.illegal && cnt != 4'hF) cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] ins, input exp_t ex, input logic ordy);
    cur = ex;
    drive(1'b1, ins, ex.pc, 1'b0, ordy);
    tick();
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 32'h0, 32'h0, 1'b0, ordy);
    tick();
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("rst_in_ready", bus0.in_ready, 1'b0);
    chk("rst_out_valid", bus0.out_valid, 1'b0);
    chk("rst_count", bus0.illegal_count, 4'd0);
    chk("rst_bundle", got0(), z(32'h0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    idle(1'b1);

    // ADD x3,x1,x2 then LW x5,-4(x2), back to back
    e = z(32'h100); e.rd = 5'd3; e.rs1 = 5'd1; e.rs2 = 5'd2; e.reg_write = 1'b1;
    go(32'h002081B3, e, 1'b1);
    e = z(32'h104); e.rd = 5'd5; e.rs1 = 5'd2; e.imm = 32'hFFFF_FFFC; e.src_imm = 1'b1;
    e.reg_write = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1; e.mem_size = 3'b010;
    go(32'hFFC12283, e, 1'b1);
    idle(1'b1);

    // Stall: SUB fills output, ADDI fills skid, SW waits at the input
    e = z(32'h200); e.rd = 5'd4; e.rs1 = 5'd5; e.rs2 = 5'd6; e.alu = 6'd1; e.reg_write = 1'b1;
    go(32'h40628233, e, 1'b0);
    e = z(32'h204); e.rd = 5'd7; e.imm = 32'hFFFF_FFFF; e.src_imm = 1'b1; e.reg_write = 1'b1;
    go(32'hFFF00393, e, 1'b0);
    e = z(32'h208); e.rs1 = 5'd5; e.rs2 = 5'd6; e.imm = 32'd8; e.src_imm = 1'b1;
    e.mem_write = 1'b1; e.mem_size = 3'b010;
    go(32'h0062A423, e, 1'b0);
    tick();
    tick();
    drive(1'b1, 32'h0062A423, 32'h208, 1'b0, 1'b1);
    tick();
    tick();
    idle(1'b1);
    idle(1'b1);

    // Illegal: BEQ with funct3=010, all-zero word, then saturate the counter
    go(32'h0000A063, ill(32'h300), 1'b1);
    go(32'h00000000, ill(32'h304), 1'b1);
    idle(1'b1);
    for (int i = 0; i < 14; i++) begin
      go((i % 2 == 0) ? 32'h00000073 : 32'h00003003, ill(32'h400 + 32'(i * 4)), 1'b1);
    end
    idle(1'b1);
    chk("count_saturated", bus0.illegal_count, 4'hF);

    // Assorted legal forms
    e = z(32'h500); e.rd = 5'd10; e.imm = 32'h1234_5000; e.alu = 6'd10; e.src_imm = 1'b1;
    e.reg_write = 1'b1; e.lui = 1'b1;
    go(32'h12345537, e, 1'b1);
    e = z(32'h504); e.rd = 5'd1; e.imm = 32'hFFFF_FFF8; e.reg_write = 1'b1; e.jump = 1'b1;
    go(32'hFF9FF0EF, e, 1'b1);
    e = z(32'h508); e.rs1 = 5'd1; e.rs2 = 5'd2; e.imm = 32'd16; e.alu = 6'd1;
    e.branch = 1'b1; e.bf3 = 3'b001;
    go(32'h00209863, e, 1'b1);
    go(32'h0FF0000F, z(32'h50C), 1'b1);
    e = z(32'h510); e.rd = 5'd5; e.rs1 = 5'd6; e.imm = 32'd3; e.alu = 6'd2; e.src_imm = 1'b1;
    e.reg_write = 1'b1;
    go(32'h00331293, e, 1'b1);
    e = z(32'h514); e.rs1 = 5'd1; e.rs2 = 5'd2;
    go(32'h00208033, e, 1'b1);
    idle(1'b1);

    // Flush with output and skid full and an instruction offered
    e = z(32'h600); e.rd = 5'd3; e.rs1 = 5'd1; e.rs2 = 5'd2; e.reg_write = 1'b1;
    go(32'h002081B3, e, 1'b0);
    e.pc = 32'h604;
    go(32'h002081B3, e, 1'b0);
    e.pc = 32'h608;
    cur = e;
    drive(1'b1, 32'h002081B3, 32'h608, 1'b1, 1'b0);
    tick();
    idle(1'b0);
    cur = ill(32'h60C);
    drive(1'b1, 32'h00000000, 32'h60C, 1'b1, 1'b0);
    tick();
    e.pc = 32'h610;
    go(32'h002081B3, e, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // MUL x1,x2,x3: illegal without M, MUL with M
    go(32'h023100B3, ill(32'h700), 1'b1);
    chk("m_valid", bus1.out_valid, 1'b1);
    chk("m_alu", bus1.alu_control, 6'd16);
    chk("m_illegal", bus1.illegal, 1'b0);
    chk("m_rd_write", {bus1.out_rd, bus1.reg_write}, {5'd1, 1'b1});
    idle(1'b1);

    // Asynchronous reset in the middle of a stall
    e = z(32'h800); e.rd = 5'd4; e.rs1 = 5'd5; e.rs2 = 5'd6; e.alu = 6'd1; e.reg_write = 1'b1;
    go(32'h40628233, e, 1'b0);
    e.pc = 32'h804;
    go(32'h40628233, e, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_out_valid", bus0.out_valid, 1'b0);
    chk("areset_in_ready", bus0.in_ready, 1'b0);
    chk("areset_bundle", got0(), z(32'h0));
    chk("areset_count", bus0.illegal_count, 4'd0);
    q.delete();
    cnt = 4'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1'b1);
    e = z(32'h900); e.rd = 5'd7; e.imm = 32'hFFFF_FFFF; e.src_imm = 1'b1; e.reg_write = 1'b1;
    go(32'hFFF00393, e, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
